// File: rtl/rom_pkg.sv
// -----------------------------------------------------------------------------
// rom_pkg
// Shared definitions for the program ROM / boot loader slice.
//   rom_state_t   : loader FSM state encoding (IDLE, LOAD, RUN)
//   ROM_DEPTH     : default number of instruction words
//   ROM_WIDTH     : default instruction word width
//   instr_t       : instruction word at the default width
// -----------------------------------------------------------------------------
package rom_pkg;

   localparam int ROM_DEPTH = 16;
   localparam int ROM_WIDTH = 8;

   typedef logic [ROM_WIDTH-1:0] instr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } rom_state_t;

endpackage

// File: rtl/rom_array.sv
// -----------------------------------------------------------------------------
// rom_array
// DEPTH x WIDTH register file backing the CPU program memory.
// Ports:
//   clk    in   system clock
//   clr    in   synchronous clear of every word (wins over a write)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  word at raddr, combinational
// -----------------------------------------------------------------------------
module rom_array
   import rom_pkg::*;
#(
   parameter int DEPTH  = ROM_DEPTH,
   parameter int WIDTH  = ROM_WIDTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
// Program memory and boot loader for the 4-bit CPU. Accepts a program image
// over a valid/ready byte stream, holds the CPU in reset while loading and
// releases it on the edge that accepts the final byte. The CPU fetches
// combinationally through addr/data in every state.
// Ports:
//   clk          in   system clock (rising edge)
//   reset        in   synchronous active-high reset
//   load_req     in   request to (re)load the image (honoured in IDLE/RUN)
//   ld_valid     in   loader byte valid
//   ld_data      in   loader byte
//   ld_last      in   final byte of the image
//   ld_ready     out  byte accepted this cycle when valid (high in LOAD)
//   addr         in   CPU fetch address
//   data         out  instruction at addr, combinational
//   cpu_n_reset  out  active-low CPU reset, released only in RUN
//   loading      out  high in LOAD
//   ovf          out  sticky: DEPTH words written without ld_last
//   csum         out  running byte sum of the image
// Configuration:
//   ROM_LOADER_CSUM_EN  when defined, csum is a live register; otherwise the
//                       port is tied to zero and no sum register exists.
// -----------------------------------------------------------------------------
module rom_loader
   import rom_pkg::*;
#(
   parameter int DEPTH  = ROM_DEPTH,
   parameter int WIDTH  = ROM_WIDTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_req,
   input  logic              ld_valid,
   input  logic [WIDTH-1:0]  ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] addr,
   output logic [WIDTH-1:0]  data,
   output logic              cpu_n_reset,
   output logic              loading,
   output logic              ovf,
   output logic [WIDTH-1:0]  csum
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_LOAD = LOAD;
   localparam logic [1:0] ST_RUN  = RUN;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] wptr;
   logic              in_load;
   logic              xfer;
   logic              load_entry;
   logic              mem_clr;

   assign in_load    = (state == ST_LOAD);
   assign xfer       = ld_valid & in_load;
   // load_req only matters outside LOAD; IDLE and RUN share the entry path.
   assign load_entry = load_req & ((state == ST_IDLE) | (state == ST_RUN));
   assign mem_clr    = reset | load_entry;

   assign ld_ready    = in_load;
   assign loading     = in_load;
   assign cpu_n_reset = (state == ST_RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         wptr  <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_RUN: begin
               if (load_req) begin
                  state <= ST_LOAD;
                  wptr  <= '0;
                  ovf   <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (xfer) begin
                  wptr <= wptr + 1'b1;
                  if (ld_last) begin
                     // ld_last takes priority: a full image that ends
                     // exactly at the last word is not an overflow.
                     state <= ST_RUN;
                  end else if (wptr == LAST_ADDR) begin
                     state <= ST_RUN;
                     ovf   <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ROM_LOADER_CSUM_EN
   logic [WIDTH-1:0] csum_q;

   always_ff @(posedge clk) begin
      if (mem_clr) begin
         csum_q <= '0;
      end else if (xfer) begin
         csum_q <= csum_q + ld_data;
      end
   end

   assign csum = csum_q;
`else
   assign csum = '0;
`endif

   rom_array #(
      .DEPTH  (DEPTH),
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .clr   (mem_clr),
      .we    (xfer),
      .waddr (wptr),
      .wdata (ld_data),
      .raddr (addr),
      .rdata (data)
   );

endmodule

// File: doc/rom_loader.md
# rom_loader

Program memory and boot loader for the 4-bit CPU: the responder on the CPU's instruction-fetch interface. It returns the instruction word at the CPU's `addr` combinationally on `data`. It accepts a program image over a valid/ready byte stream, holding the CPU in reset via `cpu_n_reset` while loading and releasing it once the image is complete. It sits on the mother board between the host/loader link and `cpu`.

## Interface
- `DEPTH`, 16, number of instruction words; power of two
- `WIDTH`, 8, instruction word width
- `ADDR_W`, $clog2(DEPTH), address width; 4 at default
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load_req`  in  1  request to (re)load the program image
- `ld_valid`  in  1  loader byte valid
- `ld_data`  in  WIDTH  loader byte
- `ld_last`  in  1  marks final byte of the image
- `ld_ready`  out  1  block accepts a byte this cycle
- `addr`  in  ADDR_W  CPU fetch address
- `data`  out  WIDTH  instruction at `addr`, combinational
- `cpu_n_reset`  out  1  active-low reset to CPU; 0 except in RUN
- `loading`  out  1  high in LOAD
- `ovf`  out  1  sticky: image filled DEPTH words without `ld_last`
- `csum`  out  WIDTH  running sum of loaded bytes (see Configuration)

## Operation
- States: IDLE, LOAD, RUN. Moore outputs: `ld_ready` = `loading` = (state==LOAD); `cpu_n_reset` = (state==RUN).
- Reset: state IDLE, write pointer `wptr`=0, all memory words 0, `ovf`=0, `csum`=0. So after reset `ld_ready`=0, `loading`=0, `cpu_n_reset`=0, and `data`=0.
- IDLE:
  - `load_req` -> LOAD on the next edge.
  - On that edge all memory words clear to 0, and `wptr`, `ovf` and `csum` clear.
- LOAD:
  - Transfer when `ld_valid & ld_ready` at a rising edge: `mem[wptr]` <= `ld_data`, `wptr` increments, `csum` += `ld_data` (mod 2^WIDTH).
  - Transfer with `ld_last`=1 -> RUN.
  - Transfer into `wptr`==DEPTH-1 with `ld_last`=0 -> RUN and `ovf` set.
  - Both conditions on the same transfer -> RUN with `ovf` unchanged.
  - `load_req` is ignored in LOAD.
  - Unwritten words stay 0.
- RUN:
  - `load_req` -> LOAD with the same clear actions as IDLE->LOAD; the CPU is re-held in reset from the next cycle.
  - `ld_valid` is ignored.
- Read port: `data` = `mem[addr]` in every state, including during LOAD.
- Reset asserted mid-LOAD or mid-RUN: full reset behaviour on that edge. Partial images are discarded.

## Timing
- Read latency 0 cycles: `data` follows `addr` combinationally.
- A byte written on edge N is visible on `data` from edge N onward (after the edge).
- `ld_ready` rises the cycle after `load_req` is sampled in IDLE/RUN. It falls on the edge that accepts the last byte.
- `cpu_n_reset` rises on the same edge that accepts the final byte. The CPU's first fetch, at address 0, sees the complete image.
- Throughput: one byte per cycle while `ld_valid` is held.
- `ld_data`/`ld_last` must be stable while `ld_valid`=1 and `ld_ready`=0. The block requires no hold after acceptance.

## Configuration
- `ROM_LOADER_CSUM_EN` defined: `csum` is a register updated as described; cleared on reset and on LOAD entry; holds its value in RUN.
- Not defined: the `csum` port is present but tied to 0, and no sum register exists.

## Structure
- Package `rom_pkg`:
  - state enum `rom_state_t` {IDLE, LOAD, RUN}
  - default `DEPTH`/`WIDTH` constants
  - `instr_t` = logic [WIDTH-1:0]
- Sub-module `rom_array`:
  - DEPTH×WIDTH register file with synchronous write (`we`, `waddr`, `wdata`)
  - synchronous clear-all (`clr`)
  - combinational read (`raddr` -> `rdata`)
- `rom_loader` holds the FSM, `wptr`, `ovf`, `csum`.

## Test plan
- Reset, then pulse `load_req`: a stream of 3 bytes (0x12, 0x34, 0x56; last on 0x56) at one per cycle -> `cpu_n_reset`=1 on the 3rd accept edge; `addr`=0/1/2/3 reads 0x12/0x34/0x56/0x00; `ovf`=0; `csum`=0x9C with the macro defined.
- Backpressure: toggle `ld_valid` 1/0 every cycle during load -> only valid cycles write; `wptr` does not advance on idle cycles; the image is correct.
- Overflow: 16 bytes 0x01..0x10 with `ld_last`=0 -> RUN after the 16th, `ovf`=1, `addr`=15 reads 0x10.
- Reload from RUN: `load_req` in RUN -> `cpu_n_reset`=0 the next cycle, memory reads 0 everywhere, then a new 1-byte image 0xAA reads at address 0.
- Reset mid-load after 2 bytes -> all outputs at reset values, `data`=0 for every `addr`, `ld_ready`=0.
- Without `ROM_LOADER_CSUM_EN`: repeat the first scenario -> `csum` stays 0 throughout.
